// File: rtl/demux_lane_scheduler.sv
// Round-robin burst scheduler in front of a 1-to-4 bit demux: picks the next
// ready lane, forwards BURST_LEN bits to it and reports done/abort/ones status.
module demux_lane_scheduler #(
   parameter int BURST_LEN = 4,
   parameter int STALL_MAX = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] lane_rdy,
   output logic       I,
   output logic       s1,
   output logic       s0,
   output logic       dmx_en,
   output logic       burst_done,
   output logic       burst_abort,
   output logic [7:0] burst_ones,
   output logic       busy
);

   // Handshake: a bit transfers on a rising edge where in_valid && in_ready;
   // in_ready is combinational and only high in BURST with the selected lane ready.

   typedef enum logic {
      ST_SCAN  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam logic [7:0] C_BURST_LEN = 8'(BURST_LEN);
   localparam logic [7:0] C_STALL_MAX = 8'(STALL_MAX);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_ptr;
   logic [1:0] r_sel;
   logic       r_i;
   logic       r_dmx_en;
   logic       r_done;
   logic       r_abort;
   logic [7:0] r_ones;
   logic [7:0] r_beat_cnt;
   logic [7:0] r_stall_cnt;
   logic [7:0] r_acc;

   logic       w_found;
   logic [1:0] w_pick;
   logic [1:0] w_idx;
   logic       w_sel_rdy;
   logic       w_in_burst;
   logic       w_accept;
   logic       w_last_beat;
   logic       w_stall;
   logic       w_stall_hit;

   // Lane search starts at ptr and wraps; first ready lane wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_ptr;
      w_idx   = r_ptr;
      for (int i = 0; i < 4; i++) begin
         w_idx = r_ptr + 2'(i);
         if (!w_found && lane_rdy[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   assign w_in_burst  = (r_state == ST_BURST);
   assign w_sel_rdy   = lane_rdy[r_sel];
   assign w_accept    = w_in_burst && w_sel_rdy && in_valid;
   assign w_last_beat = w_accept && ((r_beat_cnt + 8'd1) == C_BURST_LEN);
   assign w_stall     = w_in_burst && !w_sel_rdy;
   // A stall never coincides with an accepted beat, so completion cannot race it.
   assign w_stall_hit = w_stall && (STALL_MAX != 0) &&
                        ((r_stall_cnt + 8'd1) == C_STALL_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_SCAN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_SCAN: begin
            if (w_found) begin
               w_state_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            if (w_last_beat || w_stall_hit) begin
               w_state_nxt = ST_SCAN;
            end
         end
         default: w_state_nxt = ST_SCAN;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      if (r_state == ST_BURST) begin
         in_ready = w_sel_rdy;
         busy     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= 2'd0;
         r_sel       <= 2'd0;
         r_i         <= 1'b0;
         r_dmx_en    <= 1'b0;
         r_done      <= 1'b0;
         r_abort     <= 1'b0;
         r_ones      <= 8'd0;
         r_beat_cnt  <= 8'd0;
         r_stall_cnt <= 8'd0;
         r_acc       <= 8'd0;
      end else begin
         r_dmx_en <= w_accept;
         r_done   <= w_last_beat;
         r_abort  <= w_stall_hit && !w_last_beat;
         if (w_accept) begin
            r_i <= in_bit;
         end
         if (!w_in_burst) begin
            if (w_found) begin
               r_sel       <= w_pick;
               r_beat_cnt  <= 8'd0;
               r_stall_cnt <= 8'd0;
               r_acc       <= 8'd0;
            end
         end else begin
            if (w_accept) begin
               r_beat_cnt  <= r_beat_cnt + 8'd1;
               r_acc       <= r_acc + {7'd0, in_bit};
               r_stall_cnt <= 8'd0;
            end else if (w_stall && (r_stall_cnt != 8'hFF)) begin
               r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (w_last_beat) begin
               r_ones <= r_acc + {7'd0, in_bit};
               r_ptr  <= r_sel + 2'd1;
            end else if (w_stall_hit) begin
               r_ptr  <= r_sel + 2'd1;
            end
         end
      end
   end

   assign I           = r_i;
   assign s1          = r_sel[1];
   assign s0          = r_sel[0];
   assign dmx_en      = r_dmx_en;
   assign burst_done  = r_done;
   assign burst_abort = r_abort;
   assign burst_ones  = r_ones;

   a_done_abort_excl: assert property (@(posedge clk) disable iff (rst)
      !(r_done && r_abort));

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Directed bench for demux_lane_scheduler: a per-cycle vector table plus a
// lane-skipping sequence scored through an expected queue.
module tb_demux_lane_scheduler;

   logic       clk;
   logic       rst;
   logic       in_bit;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] lane_rdy;
   logic       I;
   logic       s1;
   logic       s0;
   logic       dmx_en;
   logic       burst_done;
   logic       burst_abort;
   logic [7:0] burst_ones;
   logic       busy;

   int checks = 0;
   int errors = 0;

   demux_lane_scheduler #(.BURST_LEN(4), .STALL_MAX(3)) dut (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(in_ready), .lane_rdy(lane_rdy), .I(I), .s1(s1), .s0(s0),
      .dmx_en(dmx_en), .burst_done(burst_done), .burst_abort(burst_abort),
      .burst_ones(burst_ones), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct packed {
      logic       rst;
      logic       v;
      logic       b;
      logic [3:0] rdy;
      logic       e_rdy;
      logic       e_i;
      logic [1:0] e_sel;
      logic       e_en;
      logic       e_done;
      logic       e_abort;
      logic [7:0] e_ones;
      logic       e_busy;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic v, input logic b,
                               input logic [3:0] rdy, input logic e_rdy,
                               input logic e_i, input logic [1:0] e_sel,
                               input logic e_en, input logic e_done,
                               input logic e_abort, input logic [7:0] e_ones,
                               input logic e_busy);
      vec_t t;
      t.rst = r; t.v = v; t.b = b; t.rdy = rdy; t.e_rdy = e_rdy;
      t.e_i = e_i; t.e_sel = e_sel; t.e_en = e_en; t.e_done = e_done;
      t.e_abort = e_abort; t.e_ones = e_ones; t.e_busy = e_busy;
      return t;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input int idx);
      @(negedge clk);
      rst      = t.rst;
      in_valid = t.v;
      in_bit   = t.b;
      lane_rdy = t.rdy;
      #1;
      chk("in_ready", idx, {7'd0, in_ready}, {7'd0, t.e_rdy});
      @(posedge clk);
      #1;
      chk("I", idx, {7'd0, I}, {7'd0, t.e_i});
      chk("sel", idx, {6'd0, s1, s0}, {6'd0, t.e_sel});
      chk("dmx_en", idx, {7'd0, dmx_en}, {7'd0, t.e_en});
      chk("burst_done", idx, {7'd0, burst_done}, {7'd0, t.e_done});
      chk("burst_abort", idx, {7'd0, burst_abort}, {7'd0, t.e_abort});
      chk("burst_ones", idx, burst_ones, t.e_ones);
      chk("busy", idx, {7'd0, busy}, {7'd0, t.e_busy});
   endtask

   vec_t tbl[45];
   logic [2:0] exp_q[$];
   logic [1:0] lane_seq[4];

   initial begin
      // rst v b rdy | in_ready | I sel en done abort ones busy
      tbl[0]  = mk(0,1,1,4'hF, 0, 0,2'd0,0,0,0,8'd0,1);
      tbl[1]  = mk(0,1,1,4'hF, 1, 1,2'd0,1,0,0,8'd0,1);
      tbl[2]  = mk(0,1,1,4'hF, 1, 1,2'd0,1,0,0,8'd0,1);
      tbl[3]  = mk(0,1,0,4'hF, 1, 0,2'd0,1,0,0,8'd0,1);
      tbl[4]  = mk(0,1,1,4'hF, 1, 1,2'd0,1,1,0,8'd3,0);
      tbl[5]  = mk(0,1,0,4'hF, 0, 1,2'd1,0,0,0,8'd3,1);
      tbl[6]  = mk(0,1,0,4'hF, 1, 0,2'd1,1,0,0,8'd3,1);
      tbl[7]  = mk(0,1,0,4'hF, 1, 0,2'd1,1,0,0,8'd3,1);
      tbl[8]  = mk(0,1,0,4'hF, 1, 0,2'd1,1,0,0,8'd3,1);
      tbl[9]  = mk(0,1,0,4'hF, 1, 0,2'd1,1,1,0,8'd0,0);
      tbl[10] = mk(0,1,1,4'hF, 0, 0,2'd2,0,0,0,8'd0,1);
      tbl[11] = mk(0,1,1,4'hF, 1, 1,2'd2,1,0,0,8'd0,1);
      tbl[12] = mk(0,1,0,4'hF, 1, 0,2'd2,1,0,0,8'd0,1);
      tbl[13] = mk(0,1,1,4'hF, 1, 1,2'd2,1,0,0,8'd0,1);
      tbl[14] = mk(0,1,0,4'hF, 1, 0,2'd2,1,1,0,8'd2,0);
      tbl[15] = mk(0,1,1,4'hF, 0, 0,2'd3,0,0,0,8'd2,1);
      tbl[16] = mk(0,1,1,4'hF, 1, 1,2'd3,1,0,0,8'd2,1);
      tbl[17] = mk(0,1,1,4'hF, 1, 1,2'd3,1,0,0,8'd2,1);
      tbl[18] = mk(0,1,1,4'hF, 1, 1,2'd3,1,0,0,8'd2,1);
      tbl[19] = mk(0,1,1,4'hF, 1, 1,2'd3,1,1,0,8'd4,0);
      tbl[20] = mk(0,0,0,4'hF, 0, 1,2'd0,0,0,0,8'd4,1);
      tbl[21] = mk(0,0,1,4'hF, 1, 1,2'd0,0,0,0,8'd4,1);
      tbl[22] = mk(0,1,0,4'hF, 1, 0,2'd0,1,0,0,8'd4,1);
      tbl[23] = mk(0,1,1,4'hF, 1, 1,2'd0,1,0,0,8'd4,1);
      tbl[24] = mk(0,1,0,4'hF, 1, 0,2'd0,1,0,0,8'd4,1);
      tbl[25] = mk(0,1,0,4'hF, 1, 0,2'd0,1,1,0,8'd1,0);
      tbl[26] = mk(0,1,1,4'hC, 0, 0,2'd2,0,0,0,8'd1,1);
      tbl[27] = mk(0,1,1,4'hC, 1, 1,2'd2,1,0,0,8'd1,1);
      tbl[28] = mk(0,1,1,4'hC, 1, 1,2'd2,1,0,0,8'd1,1);
      tbl[29] = mk(0,1,0,4'h8, 0, 1,2'd2,0,0,0,8'd1,1);
      tbl[30] = mk(0,1,0,4'h8, 0, 1,2'd2,0,0,0,8'd1,1);
      tbl[31] = mk(0,1,0,4'hC, 1, 0,2'd2,1,0,0,8'd1,1);
      tbl[32] = mk(0,1,1,4'hC, 1, 1,2'd2,1,1,0,8'd3,0);
      tbl[33] = mk(0,1,0,4'h4, 0, 1,2'd2,0,0,0,8'd3,1);
      tbl[34] = mk(0,1,1,4'h4, 1, 1,2'd2,1,0,0,8'd3,1);
      tbl[35] = mk(0,1,0,4'h4, 1, 0,2'd2,1,0,0,8'd3,1);
      tbl[36] = mk(0,1,1,4'h0, 0, 0,2'd2,0,0,0,8'd3,1);
      tbl[37] = mk(0,1,1,4'h0, 0, 0,2'd2,0,0,0,8'd3,1);
      tbl[38] = mk(0,1,1,4'h0, 0, 0,2'd2,0,0,1,8'd3,0);
      tbl[39] = mk(0,1,1,4'hF, 0, 0,2'd3,0,0,0,8'd3,1);
      tbl[40] = mk(0,1,1,4'hF, 1, 1,2'd3,1,0,0,8'd3,1);
      tbl[41] = mk(1,1,1,4'hF, 1, 0,2'd0,0,0,0,8'd0,0);
      tbl[42] = mk(1,1,1,4'hF, 0, 0,2'd0,0,0,0,8'd0,0);
      tbl[43] = mk(0,1,1,4'hF, 0, 0,2'd0,0,0,0,8'd0,1);
      tbl[44] = mk(0,1,1,4'hF, 1, 1,2'd0,1,0,0,8'd0,1);
      lane_seq[0] = 2'd1; lane_seq[1] = 2'd3; lane_seq[2] = 2'd1; lane_seq[3] = 2'd3;

      // Clock/reset
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; lane_rdy = 4'h0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 45; i++) begin
         apply(tbl[i], i);
      end

      // Lane skipping with lane_rdy = 1010: bursts go to lanes 1,3,1,3.
      begin
         int beats;
         int accepted;
         int cyc;
         logic [7:0] ones_acc;
         logic [2:0] exp_beat;
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1;
         chk("skip_reset_busy", 0, {7'd0, busy}, 8'd0);
         beats = 0; accepted = 0; cyc = 0; ones_acc = 8'd0;
         while (beats < 16 && cyc < 40) begin
            @(negedge clk);
            rst      = 1'b0;
            lane_rdy = 4'b1010;
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
            #1;
            if (in_ready && accepted < 16) begin
               exp_q.push_back({lane_seq[accepted / 4], in_bit});
               accepted++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (dmx_en) begin
               if (exp_q.size() == 0) begin
                  chk("skip_unexpected_beat", cyc, 8'd1, 8'd0);
               end else begin
                  exp_beat = exp_q.pop_front();
                  chk("skip_beat", cyc, {5'd0, s1, s0, I}, {5'd0, exp_beat});
               end
               ones_acc = ones_acc + {7'd0, I};
               beats++;
            end
            if (burst_done) begin
               chk("skip_done_pos", cyc, 8'(beats % 4), 8'd0);
               chk("skip_ones", cyc, burst_ones, ones_acc);
               ones_acc = 8'd0;
            end
            if (burst_abort) begin
               chk("skip_abort", cyc, 8'd1, 8'd0);
            end
         end
         chk("skip_beats", 0, 8'(beats), 8'd16);
         chk("skip_cycles", 0, 8'(cyc), 8'd20);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
